// File: rtl/rbr_pkg.sv
`default_nettype none
// ============================================================================
// Package     : rbr_pkg
// Description : Redundant binary representation types shared by SO3S stages.
// Revision    : 1.0 - initial release
// ============================================================================
package rbr_pkg;

    // A digit in {-1,0,+1}: plus=1 is +1, minus=1 is -1, both 0 is zero.
    typedef struct packed {
        logic plus;
        logic minus;
    } signed_digit;

endpackage
`default_nettype wire

// File: rtl/so3s_select_stage.sv
`default_nettype none
// ============================================================================
// Module      : so3s_select_stage
// Description : Registered digit selection and residual correction stage
//               following each so3s_2D_stage; sequences the online delay.
// Revision    : 1.0 - initial release
// ============================================================================
module so3s_select_stage #(
    parameter int FULL_WIDTH = 15,
    parameter int IB_WIDTH   = 3,
    parameter int DELTA      = 3,
    parameter int N_DIGITS   = 12,
    parameter int CNT_W      = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [3:0]                s,
    input  logic [FULL_WIDTH-1:0]     ws_in,
    input  logic [FULL_WIDTH-1:0]     wc_in,
    input  logic [6*FULL_WIDTH-1:0]   apd_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [FULL_WIDTH-1:0]     ws_out,
    output logic [FULL_WIDTH-1:0]     wc_out,
    output logic [6*FULL_WIDTH-1:0]   apd_out,
    output rbr_pkg::signed_digit      d_out,
    output logic                      d_valid,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    localparam int              c_low_w     = FULL_WIDTH - IB_WIDTH;
    localparam logic [CNT_W-1:0] c_warm_last = CNT_W'((DELTA > 0) ? DELTA - 1 : 0);
    localparam logic [CNT_W-1:0] c_run_last  = CNT_W'(N_DIGITS - 1);
    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

    state_t                    r_state;
    logic [CNT_W-1:0]          r_count;
    logic                      r_out_valid;
    logic                      r_d_valid;
    rbr_pkg::signed_digit      r_d_out;
    logic [FULL_WIDTH-1:0]     r_ws_out;
    logic [FULL_WIDTH-1:0]     r_wc_out;
    logic [6*FULL_WIDTH-1:0]   r_apd_out;

    logic                      w_accepting;
    logic                      w_xfer;
    logic                      w_drain_empty;
    rbr_pkg::signed_digit      w_sel;
    logic [IB_WIDTH-1:0]       w_r;
    logic                      w_unused_int;

    assign w_accepting   = (r_state == WARMUP) || (r_state == RUN);
    assign in_ready      = w_accepting && (!r_out_valid || out_ready);
    assign w_xfer        = in_valid && in_ready;
    assign w_drain_empty = !r_out_valid || out_ready;

    // s >= 1 -> +1, s <= -2 -> -1, s in {-1,0} -> 0
    assign w_sel.plus  = !s[3] && (s != 4'd0);
    assign w_sel.minus = s[3] && (s != 4'hF);

    // Only the low IB_WIDTH bits of s - d survive, so compute them directly.
    assign w_r = s[IB_WIDTH-1:0] + IB_WIDTH'(w_sel.minus) - IB_WIDTH'(w_sel.plus);

    // Incoming integer fields arrive already stripped and are overwritten.
    assign w_unused_int = ^{ws_in[FULL_WIDTH-1 -: IB_WIDTH], wc_in[FULL_WIDTH-1 -: IB_WIDTH]};

    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DRAIN) && w_drain_empty;
    assign out_valid = r_out_valid;
    assign d_valid   = r_d_valid;
    assign d_out     = r_d_out;
    assign ws_out    = r_ws_out;
    assign wc_out    = r_wc_out;
    assign apd_out   = r_apd_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_d_valid   <= 1'b0;
            r_d_out     <= '0;
            r_ws_out    <= '0;
            r_wc_out    <= '0;
            r_apd_out   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_count <= '0;
                        if (DELTA == 0) begin
                            r_state <= RUN;
                        end else begin
                            r_state <= WARMUP;
                        end
                    end
                end
                WARMUP: begin
                    if (w_xfer) begin
                        if (r_count == c_warm_last) begin
                            r_state <= RUN;
                            r_count <= '0;
                        end else begin
                            r_count <= r_count + c_one;
                        end
                    end
                end
                RUN: begin
                    if (w_xfer) begin
                        r_count <= r_count + c_one;
                        if (r_count == c_run_last) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_drain_empty) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_d_valid   <= (r_state == RUN);
                r_d_out     <= (r_state == RUN) ? w_sel : '0;
                r_ws_out    <= {w_r, ws_in[c_low_w-1:0]};
                r_wc_out    <= {{IB_WIDTH{1'b0}}, wc_in[c_low_w-1:0]};
                r_apd_out   <= apd_in;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
                r_d_valid   <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_so3s_select_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_so3s_select_stage
// Description : Directed self-checking bench for so3s_select_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_so3s_select_stage;

    localparam int FW    = 15;
    localparam int DELTA = 3;
    localparam int NB    = 15;
    localparam int BW    = 8 * FW + 3;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b0;
    logic [3:0]         s = '0;
    logic [FW-1:0]      ws_in = '0;
    logic [FW-1:0]      wc_in = '0;
    logic [6*FW-1:0]    apd_in = '0;
    logic               in_ready;
    logic               out_valid;
    logic [FW-1:0]      ws_out;
    logic [FW-1:0]      wc_out;
    logic [6*FW-1:0]    apd_out;
    rbr_pkg::signed_digit d_out;
    logic               d_valid;
    logic               busy;
    logic               done;
    logic [BW-1:0]      obs;

    int checks = 0;
    int failures = 0;

    // Per-beat stimulus tables: s, expected corrected top field, {plus,minus}.
    logic [3:0] s_tab   [8] = '{4'b0011, 4'b1101, 4'b1111, 4'b0000, 4'b0001, 4'b1110, 4'b0010, 4'b1100};
    logic [2:0] top_tab [8] = '{3'b010, 3'b110, 3'b111, 3'b000, 3'b000, 3'b111, 3'b001, 3'b101};
    logic [1:0] d_tab   [8] = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b10, 2'b01, 2'b10, 2'b01};

    logic [BW-1:0] rec_beat [32];
    int rec_n, done_cnt, done_cyc, acc15_cyc, first_acc;
    int stall_seen, stall_rdy, stall_chg;
    logic end_idle;

    so3s_select_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s         (s),
        .ws_in     (ws_in),
        .wc_in     (wc_in),
        .apd_in    (apd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ws_out    (ws_out),
        .wc_out    (wc_out),
        .apd_out   (apd_out),
        .d_out     (d_out),
        .d_valid   (d_valid),
        .busy      (busy),
        .done      (done)
    );

    assign obs = {ws_out, wc_out, apd_out, d_valid, d_out};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no summary, required run to finish");
        $fatal(1, "watchdog");
    end

    task automatic drive_beat(input int k);
        s      = s_tab[k % 8];
        ws_in  = {3'b101, 12'(k)};
        wc_in  = {3'b111, ~12'(k)};
        apd_in = {6{15'(k + 7)}};
    endtask

    function automatic logic [BW-1:0] exp_beat(input int j);
        logic          dv;
        logic [1:0]    d;
        dv = (j >= DELTA);
        d  = dv ? d_tab[j % 8] : 2'b00;
        return {top_tab[j % 8], 12'(j), 3'b000, ~12'(j), {6{15'(j + 7)}}, dv, d};
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        s = '0; ws_in = '0; wc_in = '0; apd_in = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs one operation from start to done, recording every consumed beat.
    task automatic run_op(input int st_at, input int st_len, input bit poke);
        int cyc;
        int acc;
        bit prev_stalled;
        logic [BW-1:0] snap;
        rec_n = 0; done_cnt = 0; done_cyc = -100; acc15_cyc = -1; first_acc = -1;
        stall_seen = 0; stall_rdy = 0; stall_chg = 0;
        prev_stalled = 1'b0; snap = '0; acc = 0; cyc = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (cyc < 200 && !(done_cnt > 0 && cyc > done_cyc + 3)) begin
            out_ready = !(st_len > 0 && cyc >= st_at && cyc < st_at + st_len);
            start     = poke && (cyc == 8);
            in_valid  = (acc < NB);
            drive_beat(acc);
            #1;
            if (out_valid && !out_ready) begin
                stall_seen++;
                if (in_ready) stall_rdy++;
                if (prev_stalled && obs !== snap) stall_chg++;
                snap = obs;
                prev_stalled = 1'b1;
            end else begin
                prev_stalled = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (rec_n < 32) rec_beat[rec_n] = obs;
                rec_n++;
            end
            if (in_valid && in_ready) begin
                if (first_acc < 0) first_acc = cyc;
                acc++;
                if (acc == NB) acc15_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        end_idle = !busy && !in_ready;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'($urandom); in_valid = 1'($urandom); out_ready = 1'($urandom);
            s = 4'($urandom); ws_in = 15'($urandom); wc_in = 15'($urandom);
            apd_in = {$urandom, $urandom, $urandom};
            #1;
            checks++;
            if ({out_valid, d_valid, done, busy, in_ready, obs} !== '0) begin
                failures++;
                $display("FAIL reset_state cycle %0d: got %h required 0", i,
                         {out_valid, d_valid, done, busy, in_ready, obs});
            end
        end
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        #1;
        checks++;
        if ({in_ready, busy, done} !== 3'b110) begin
            failures++;
            $display("FAIL reset_start: got in_ready/busy/done=%b required 110", {in_ready, busy, done});
        end
        apply_reset();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        run_op(0, 0, 1'b0);
        checks++;
        if (rec_n !== NB) begin
            failures++;
            $display("FAIL b2b_count: got %0d beats required %0d", rec_n, NB);
        end
        for (int j = 0; j < rec_n && j < 32; j++) begin
            checks++;
            if (rec_beat[j] !== exp_beat(j)) begin
                failures++;
                $display("FAIL b2b_beat %0d: got %h required %h", j, rec_beat[j], exp_beat(j));
            end
        end
        checks++;
        if (acc15_cyc - first_acc !== NB - 1) begin
            failures++;
            $display("FAIL b2b_throughput: got span %0d required %0d", acc15_cyc - first_acc, NB - 1);
        end
        checks++;
        if (done_cnt !== 1 || done_cyc !== acc15_cyc + 1) begin
            failures++;
            $display("FAIL b2b_done: got count %0d at %0d required 1 at %0d", done_cnt, done_cyc, acc15_cyc + 1);
        end
        checks++;
        if (end_idle !== 1'b1) begin
            failures++;
            $display("FAIL b2b_idle: got %b required 1", end_idle);
        end
    endtask

    task automatic test_selection();
        logic [3:0]  sv  [4] = '{4'b0011, 4'b1101, 4'b1111, 4'b0000};
        logic [2:0]  top [4] = '{3'b010, 3'b110, 3'b111, 3'b000};
        logic [1:0]  dd  [4] = '{2'b10, 2'b01, 2'b00, 2'b00};
        apply_reset();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        ws_in = '0; wc_in = '1; s = '0; apd_in = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            s = sv[i];
            @(negedge clk);
            #1;
            checks++;
            if ({ws_out, wc_out, d_valid, d_out} !== {top[i], 12'd0, 3'b000, 12'hFFF, 1'b1, dd[i]}) begin
                failures++;
                $display("FAIL select s=%b: got ws=%h wc=%h dv=%b d=%b required ws=%h wc=%h dv=1 d=%b",
                         sv[i], ws_out, wc_out, d_valid, d_out, {top[i], 12'd0}, {3'b000, 12'hFFF}, dd[i]);
            end
        end
        apply_reset();
    endtask

    task automatic test_backpressure();
        apply_reset();
        run_op(6, 4, 1'b0);
        checks++;
        if (stall_seen !== 4 || stall_rdy !== 0 || stall_chg !== 0) begin
            failures++;
            $display("FAIL bp_hold: got stalls=%0d ready_during=%0d changes=%0d required 4/0/0",
                     stall_seen, stall_rdy, stall_chg);
        end
        checks++;
        if (rec_n !== NB) begin
            failures++;
            $display("FAIL bp_count: got %0d beats required %0d", rec_n, NB);
        end
        for (int j = 0; j < rec_n && j < 32; j++) begin
            checks++;
            if (rec_beat[j] !== exp_beat(j)) begin
                failures++;
                $display("FAIL bp_beat %0d: got %h required %h", j, rec_beat[j], exp_beat(j));
            end
        end
        checks++;
        if (done_cnt !== 1 || end_idle !== 1'b1) begin
            failures++;
            $display("FAIL bp_done: got count %0d idle %b required 1 1", done_cnt, end_idle);
        end
    endtask

    task automatic test_start_in_run();
        int ndv;
        apply_reset();
        run_op(0, 0, 1'b1);
        ndv = 0;
        for (int j = 0; j < rec_n && j < 32; j++) ndv += int'(rec_beat[j][2]);
        checks++;
        if (rec_n !== NB || ndv !== NB - DELTA) begin
            failures++;
            $display("FAIL start_run_count: got beats %0d digits %0d required %0d %0d", rec_n, ndv, NB, NB - DELTA);
        end
        checks++;
        if (done_cnt !== 1 || done_cyc !== NB) begin
            failures++;
            $display("FAIL start_run_done: got count %0d at %0d required 1 at %0d", done_cnt, done_cyc, NB);
        end
    endtask

    task automatic test_reset_mid_run();
        int ndone;
        int nbusy;
        int ndv;
        apply_reset();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            drive_beat(k);
            @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, d_valid, done, busy, in_ready, obs} !== '0) begin
            failures++;
            $display("FAIL midrst_clear: got %h required 0", {out_valid, d_valid, done, busy, in_ready, obs});
        end
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0; nbusy = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (done) ndone++;
            if (busy) nbusy++;
        end
        checks++;
        if (ndone !== 0 || nbusy !== 0) begin
            failures++;
            $display("FAIL midrst_nodone: got done %0d busy %0d required 0 0", ndone, nbusy);
        end
        in_valid = 1'b0;
        run_op(0, 0, 1'b0);
        ndv = 0;
        for (int j = 0; j < rec_n && j < 32; j++) ndv += int'(rec_beat[j][2]);
        checks++;
        if (rec_n !== NB || ndv !== NB - DELTA || done_cnt !== 1) begin
            failures++;
            $display("FAIL midrst_rerun: got beats %0d digits %0d done %0d required %0d %0d 1",
                     rec_n, ndv, done_cnt, NB, NB - DELTA);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_selection();
        test_backpressure();
        test_start_in_run();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/so3s_select_stage.md
Name: so3s_select_stage

Overview:
- Registered digit-selection stage. It sits directly downstream of each so3s_2D_stage in the online sum-of-squares (SO3S) pipeline.
- It consumes the stage's 4-bit residual estimate s and its residual/append vectors, and selects the output signed digit.
- It reinserts the corrected integer part into the residual and registers everything for the next so3s_2D_stage.
- It also sequences the online delay: warm-up beats emit no digit, then N_DIGITS digits follow, then done is pulsed.

Parameters:
FULL_WIDTH, 15, width of every residual/append vector.
IB_WIDTH, 3, integer bits of the residual; legal range 2..4.
DELTA, 3, online delay: number of warm-up beats before the first valid digit.
N_DIGITS, 12, number of output digits per operation; must be at least 1.
CNT_W, 5, counter width; must satisfy 2^CNT_W > DELTA+N_DIGITS.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse that begins an operation; honoured only in IDLE
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept a beat
s  in  4  two's-complement residual estimate from upstream
ws_in  in  FULL_WIDTH  residual sum vector, integer field already stripped
wc_in  in  FULL_WIDTH  residual carry vector, integer field already stripped
apd_in  in  6*FULL_WIDTH  {xp,xm,yp,ym,zp,zm} append vectors, passed through
out_valid  out  1  output register holds a beat
out_ready  in  1  downstream accepts a beat
ws_out  out  FULL_WIDTH  corrected residual sum
wc_out  out  FULL_WIDTH  residual carry
apd_out  out  6*FULL_WIDTH  registered apd_in
d_out  out  signed_digit  selected digit (rbr_pkg signed_digit: plus, minus)
d_valid  out  1  d_out is a real result digit; low during warm-up
busy  out  1  state is not IDLE
done  out  1  one-cycle pulse at end of operation

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0.
  - out_valid=0, d_valid=0, done=0, busy=0.
  - d_out={plus=0,minus=0}; ws_out, wc_out, apd_out all 0.
  - in_ready=0.
  - Any in-flight beat is discarded. No done pulse follows reset.
- States: IDLE, WARMUP, RUN, DRAIN.
  - IDLE: start=1 moves to WARMUP and clears the counter; if DELTA=0, start moves straight to RUN.
  - WARMUP: counter increments per accepted beat. After DELTA accepted beats, moves to RUN and clears the counter.
  - RUN: counter increments per accepted beat. On the N_DIGITS-th accepted beat, moves to DRAIN.
  - DRAIN: in_ready=0. When the output register empties (out_valid=0, or out_valid & out_ready), done=1 for that cycle and the state moves to IDLE.
  - start outside IDLE is ignored.
- Handshake:
  - in_ready = (state is WARMUP or RUN) & (!out_valid | out_ready).
  - A transfer occurs when in_valid & in_ready.
  - The output register loads on every transfer; the beat is visible the next cycle, so latency is 1 cycle.
  - out_valid clears when out_ready=1 and there is no new transfer.
  - Simultaneous drain and load sustains full throughput, one beat per cycle.
  - Output fields stay stable while out_valid & !out_ready.
- Selection (s read as signed, -8..7):
  - s >= 1 selects d=+1 (plus=1, minus=0).
  - s <= -2 selects d=-1 (plus=0, minus=1).
  - s in {-1,0} selects d=0.
- Correction:
  - r = s - d, computed in 4 bits.
  - ws_out = ws_in with ws_out[FULL_WIDTH-1 -: IB_WIDTH] = r[IB_WIDTH-1:0]; lower bits from ws_in.
  - wc_out = wc_in with its top IB_WIDTH bits forced to 0.
  - apd_out = apd_in, unmodified.
- Warm-up beats:
  - Residual correction is applied as normal.
  - d_out is forced to {0,0} and d_valid=0.
- RUN beats: d_valid=1 and d_out is the selected digit.
- Width rules: no truncation other than r to IB_WIDTH. Callers guarantee |r| fits in IB_WIDTH.
- Counter wrap does not occur within legal parameters.

Test Plan:
1. Reset with all inputs toggling: all outputs at reset values, in_ready=0. Release rst_n, pulse start: in_ready=1 next cycle, busy=1.
2. DELTA=3, N_DIGITS=12, in_valid and out_ready held at 1:
   - 15 beats transfer back-to-back.
   - d_valid=0 on output beats 1-3 and 1 on beats 4-15.
   - done pulses exactly once, the cycle after the beat-15 handshake, then the state is IDLE.
3. Selection, IB_WIDTH=3, ws_in=0:
   - s=4'b0011: d=+1, ws_out[14:12]=3'b010.
   - s=4'b1101: d=-1, ws_out[14:12]=3'b110.
   - s=4'b1111: d=0, top=3'b111.
   - s=4'b0000: d=0, top=3'b000.
   - wc_out top bits 0 in all cases.
4. Backpressure: out_ready=0 for 4 cycles with out_valid=1. in_ready=0, outputs held bit-stable, no beat lost or duplicated; the sequence resumes in order when out_ready=1.
5. start asserted during RUN: ignored, counter unchanged.
6. rst_n dropped mid-RUN: outputs clear immediately, no done pulse. A fresh start then yields a full DELTA+N_DIGITS sequence.
